// File: rtl/mcpu_pkg.sv
// Shared types and constants for the fetch stage and the IF/ID link.
package mcpu_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT      = 2'd1,
      WAIT_KILL = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // IF/ID payload, consumed unchanged by the ID stage.
   typedef struct packed {
      logic [31:2] pcp1;
      logic [31:0] instr;
   } if_id_t;

   // Word-address increment; wraps modulo 2^30.
   function automatic logic [29:0] pc_inc(input logic [29:0] pc);
      return pc + 30'd1;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetch response that arrives while ID is stalled.
module fetch_skid_buf
   import mcpu_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load_i,
   input  logic   drain_i,
   input  logic   clear_i,
   input  if_id_t data_i,
   output logic   full_o,
   output if_id_t data_o
);

   logic   full_q, full_d;
   if_id_t data_q, data_d;

   // Clear wins over load, load wins over drain.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end else if (drain_i) begin
         full_d = 1'b0;
      end
   end

   // Buffer storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to instruction memory, drives IF/ID.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | no fetch outstanding, may request
// WAIT      | one fetch outstanding, response will be kept
// WAIT_KILL | one fetch outstanding, response will be dropped
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = mcpu_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mcpu_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        jpc_avail,
   input  logic [29:0] jpc,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [29:0] id_pcp1,
   output logic [31:0] id_instr
);

   import mcpu_pkg::*;

   fetch_state_t state_q, state_d;
   logic         go_q;
   logic [29:0]  pc_q, pc_d;
   logic [29:0]  issued_q, issued_d;
   logic         pend_q, pend_d;
   logic [29:0]  tgt_q, tgt_d;
   logic         id_valid_q, id_valid_d;
   logic [29:0]  id_pcp1_q, id_pcp1_d;
   logic [31:0]  id_instr_q, id_instr_d;

   logic         skid_load, skid_drain, skid_clear, skid_full;
   if_id_t       skid_in, skid_out;

   logic [29:0]  fetch_addr;
   logic         hs;
   logic         resp;

   // A redirect parked behind an in-flight grant lives for exactly one cycle;
   // if memory is requested in that cycle the target must already be used.
   assign fetch_addr = pend_q ? tgt_q : pc_q;
   assign imem_req   = go_q & (state_q == IDLE) & ~skid_full & ~flush;
   assign imem_addr  = fetch_addr;
   assign hs         = imem_req & imem_gnt;
   assign resp       = (state_q == WAIT) & imem_rvalid;
   assign skid_in    = {pc_inc(issued_q), imem_rdata};

   // Outstanding-fetch tracking.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (hs) state_d = WAIT;
         WAIT:      if (imem_rvalid) state_d = IDLE;
                    else if (flush) state_d = WAIT_KILL;
         WAIT_KILL: if (imem_rvalid) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // PC, issued address and redirect bookkeeping.
   always_comb begin
      pc_d     = pc_q;
      issued_d = issued_q;
      pend_d   = pend_q;
      tgt_d    = tgt_q;
      if (flush) begin
         pend_d = 1'b0;
         if (jpc_avail) pc_d = jpc;
      end else begin
         if (hs) begin
            pc_d     = pc_inc(fetch_addr);
            issued_d = fetch_addr;
            pend_d   = 1'b0;
         end else if (pend_q) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
         end
         // The delay slot is whatever was last granted; the target takes over after it.
         if (jpc_avail && !stall) begin
            if (state_q == IDLE && !hs) begin
               pc_d   = jpc;
               pend_d = 1'b0;
            end else begin
               pend_d = 1'b1;
               tgt_d  = jpc;
            end
         end
      end
   end

   // IF/ID register and skid control.
   always_comb begin
      id_valid_d = id_valid_q;
      id_pcp1_d  = id_pcp1_q;
      id_instr_d = id_instr_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         skid_clear = 1'b1;
      end else if (stall) begin
         if (resp) skid_load = 1'b1;
      end else if (skid_full) begin
         id_valid_d = 1'b1;
         id_pcp1_d  = skid_out.pcp1;
         id_instr_d = skid_out.instr;
         skid_drain = 1'b1;
      end else if (resp) begin
         id_valid_d = 1'b1;
         id_pcp1_d  = skid_in.pcp1;
         id_instr_d = imem_rdata;
      end else begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
      end
   end

   // State registers; go_q keeps the request low for the first cycle out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         go_q       <= 1'b0;
         pc_q       <= RESET_PC[31:2];
         issued_q   <= '0;
         pend_q     <= 1'b0;
         tgt_q      <= '0;
         id_valid_q <= 1'b0;
         id_pcp1_q  <= '0;
         id_instr_q <= NOP_INSTR;
      end else begin
         state_q    <= state_d;
         go_q       <= 1'b1;
         pc_q       <= pc_d;
         issued_q   <= issued_d;
         pend_q     <= pend_d;
         tgt_q      <= tgt_d;
         id_valid_q <= id_valid_d;
         id_pcp1_q  <= id_pcp1_d;
         id_instr_q <= id_instr_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (skid_clear),
      .data_i  (skid_in),
      .full_o  (skid_full),
      .data_o  (skid_out)
   );

   assign id_valid = id_valid_q;
   assign id_pcp1  = id_pcp1_q;
   assign id_instr = id_instr_q;

   // A response with nothing outstanding is a memory-side protocol error.
   a_rvalid_idle: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && state_q == IDLE));

endmodule
